rsi_engine_ctrl: RTL and testbench
==================================

Name: rsi_engine_ctrl

Overview:
- Sequences the Relative Strength Index computation over a UQ8.8 price stream.
- Forms per-sample gain/loss and keeps Wilder-smoothed average gain/loss in UQ16.16.
- Time-shares one iterative divider across three divisions per sample and emits RSI in UQ8.8 (0.0–100.0).
- Sits between the price ingest interface and the indicator output interface.

Parameters:
- N, 14, RSI period; legal range 2..255; package default PARAM_N.
- DIV_W, 48, divider numerator/quotient width in bits; one quotient bit per cycle.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous restart; aborts any division and re-enters warm-up
- price_valid  in  1  price sample valid
- price_ready  out  1  engine can accept a sample
- price  in  16  price, UQ8.8
- rsi_valid  out  1  result valid
- rsi_ready  in  1  consumer accepts result
- rsi  out  16  RSI, UQ8.8
- warm  out  1  high once the first N deltas are absorbed; stays high until reset/clr

Behaviour:
- Reset (rst_n low, async) or clr (sync, priority over all else) clears the following:
  - price_ready=1, rsi_valid=0, rsi=0, warm=0.
  - Count, sums and averages to 0.
  - State to FIRST.
- FSM states: FIRST, ACCUM, DIV_G, DIV_L, DIV_R, OUT.
- Accept happens on a cycle where price_valid && price_ready. price_ready=1 only in FIRST, ACCUM, or RUN-idle (ACCUM with warm=1).
- FIRST: on accept, store prev=price and go to ACCUM. No output.
- ACCUM, per accept:
  - gain = price>prev ? price-prev : 0; loss = prev>price ? prev-price : 0; then prev=price.
  - gain/loss are zero-extended to UQ16.16 (shift left 8).
  - warm=0: add gain/loss to sum_g/sum_l and increment cnt. When cnt reaches N, go to DIV_G in seed mode; otherwise stay in ACCUM.
  - warm=1: go to DIV_G in run mode.
- DIV_G: avg_g = numerator/N.
  - Seed mode: numerator = sum_g.
  - Run mode: numerator = avg_g*(N-1)+gain.
- DIV_L: the same computation for avg_l.
- DIV_R: rsi_q = (25600*avg_g)/(avg_g+avg_l).
  - If avg_g+avg_l==0, skip the divide and set rsi=0x3200 (50.0).
  - Saturate rsi at 0x6400.
  - Set warm=1 at the end of seed mode.
- Each DIV_* state occupies DIV_W+1 cycles: 1 load cycle plus DIV_W iterations. Quotients are truncated; the averages keep the low 32 bits.
- Latency: rsi_valid rises exactly 3*(DIV_W+1)+1 = 148 cycles after the accepting edge (default DIV_W). The skipped-divide case has the same latency.
- OUT: rsi_valid=1 and rsi held stable until rsi_ready.
  - Handshake completes on the cycle with rsi_valid && rsi_ready.
  - On that edge: rsi_valid=0, price_ready=1, return to ACCUM.
  - price_ready=0 throughout DIV_* and OUT, so no sample is dropped and none is buffered.
- First output occurs after N+1 prices.
- Equal consecutive prices give gain=loss=0.
- Widths: avg_g*(N-1)+gain requires at most 40 bits. 25600*avg_g requires at most 47 bits. Both fit DIV_W=48.
- Reset or clr during DIV_* or OUT discards the result without emitting it.

Optional Feature:
- Macro RSI_ROUND_EN.
- Defined: each division adds denominator>>1 to the numerator (round-half-up) before dividing. Latency is unchanged.
- Undefined: truncating division. All values in the Test Plan assume undefined.

Decomposition:
- Add to fixed_pkg:
  - typedef uq40_t (40-bit numerator).
  - typedef div_t (logic [DIV_W-1:0]).
  - localparams RSI_100=16'h6400, RSI_50=16'h3200, RSI_SCALE=25600.
  - enum rsi_state_e.
- One sub-module, seq_divider: restoring divider with start/busy/done, DIV_W-bit numerator, 32-bit denominator, DIV_W+1 cycle latency, async active-low reset.

Test Plan:
- Reset: hold rst_n=0 with price_valid=1 -> price_ready=1, rsi_valid=0, rsi=0, warm=0. No accept while in reset.
- Rising ramp: prices 10.0..24.0 step 1.0 (0x0A00..0x1800, 15 samples) -> one result rsi=0x6400 exactly 148 cycles after the 15th accept; warm=1.
- Run-mode update: continue from the ramp with price 22.0 (0x1600) -> avg_g=0x0000EDB6, avg_l=0x00002492, rsi=0x56AA.
- Flat input: 15× price 50.0 -> rsi=0x3200. Alternating 10.0/11.0 (15 samples) -> rsi=0x3200.
- Back-pressure: rsi_ready=0 for 20 cycles at OUT -> rsi stable, price_ready=0, price_valid held and not accepted. Release -> one handshake, then the next price is accepted.
- Abort: clr (and separately rst_n) mid-DIV_L -> no rsi_valid, warm=0. The next output appears only after 15 further prices.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared fixed-point types, constants and FSM encoding for the RSI engine.
// Exposes PARAM_N, DIV_W, uq8_8_t/uq16_16_t/uq40_t/div_t, RSI_* and rsi_state_e.
package fixed_pkg;

  localparam int unsigned PARAM_N = 14;
  localparam int unsigned DIV_W   = 48;

  typedef logic [15:0]      uq8_8_t;
  typedef logic [31:0]      uq16_16_t;
  typedef logic [39:0]      uq40_t;
  typedef logic [DIV_W-1:0] div_t;

  localparam logic [15:0] RSI_100   = 16'h6400;
  localparam logic [15:0] RSI_50    = 16'h3200;
  localparam logic [15:0] RSI_SCALE = 16'd25600;

  typedef enum logic [2:0] {
    ST_FIRST,
    ST_ACCUM,
    ST_DIV_G,
    ST_DIV_L,
    ST_DIV_R,
    ST_OUT
  } rsi_state_e;

  function automatic uq16_16_t to_uq16(uq8_8_t v);
    return {8'h00, v, 8'h00};
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: DIV_W-bit numerator / 32-bit denominator, one bit per cycle.
// Ports: clk, rst_n, abort, start, num, den -> busy, done, quo (valid while done).
module seq_divider
  import fixed_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        start,
  input  div_t        num,
  input  logic [31:0] den,
  output logic        busy,
  output logic        done,
  output div_t        quo
);

  localparam int CW = $clog2(DIV_W + 1);

  div_t          quo_q;
  logic [31:0]   rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [32:0] shifted;
  logic [33:0] diff;
  logic        ge;
  logic [31:0] rem_nxt;
  div_t        quo_nxt;

  always_comb begin
    shifted = {rem_q, quo_q[DIV_W-1]};
    diff    = {1'b0, shifted} - {2'b00, den};
    ge      = ~diff[33];
    rem_nxt = ge ? diff[31:0] : shifted[31:0];
    quo_nxt = {quo_q[DIV_W-2:0], ge};
  end

  // done flags the edge that retires the last bit, so the
  // caller captures quo_nxt with no extra cycle
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign quo  = quo_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end else if (start) begin
      quo_q  <= num;
      rem_q  <= '0;
      cnt_q  <= CW'(DIV_W);
      busy_q <= 1'b1;
    end
  end

endmodule

// File: rtl/rsi_engine_ctrl.sv
// RSI sequencer: Wilder-smoothed gain/loss over UQ8.8 prices, RSI out in UQ8.8.
// Ports: clk, rst_n, clr, price_valid/ready/price, rsi_valid/ready/rsi, warm.
// Define RSI_ROUND_EN for round-half-up divisions (default: truncate).
module rsi_engine_ctrl
  import fixed_pkg::*;
#(
  parameter int unsigned N = PARAM_N
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        price_valid,
  output logic        price_ready,
  input  logic [15:0] price,
  output logic        rsi_valid,
  input  logic        rsi_ready,
  output logic [15:0] rsi,
  output logic        warm
);

  rsi_state_e state_q, state_d;

  uq8_8_t     prev_q;
  logic [7:0] cnt_q;
  uq16_16_t   sum_g_q, sum_l_q;
  uq16_16_t   avg_g_q, avg_l_q;
  uq16_16_t   gain_q, loss_q;
  logic       warm_q;
  logic       rsi_valid_q;
  logic [15:0] rsi_q;

  logic     accept;
  uq8_8_t   gain_c, loss_c;
  uq16_16_t g32, l32;
  uq16_16_t avg_sum;
  logic     cnt_last;

  logic        div_start, div_busy, div_done;
  div_t        div_num, num_raw, div_quo;
  logic [31:0] div_den;
  logic [15:0] rsi_new;

  function automatic div_t run_num(uq16_16_t avg, uq16_16_t d);
    uq40_t t;
    t = uq40_t'(avg) * uq40_t'(N - 1) + uq40_t'(d);
    return div_t'(t);
  endfunction

  assign accept   = price_valid && price_ready;
  assign gain_c   = (price > prev_q) ? price - prev_q : '0;
  assign loss_c   = (prev_q > price) ? prev_q - price : '0;
  assign g32      = to_uq16(gain_c);
  assign l32      = to_uq16(loss_c);
  assign avg_sum  = avg_g_q + avg_l_q;
  assign cnt_last = (cnt_q == 8'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= ST_FIRST;
    else if (clr) state_q <= ST_FIRST;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FIRST: if (accept) state_d = ST_ACCUM;
      ST_ACCUM:
        if (accept && (warm_q || cnt_last))
          state_d = ST_DIV_G;
      ST_DIV_G: if (div_done) state_d = ST_DIV_L;
      ST_DIV_L: if (div_done) state_d = ST_DIV_R;
      ST_DIV_R: if (div_done) state_d = ST_OUT;
      ST_OUT:
        if (rsi_valid_q && rsi_ready)
          state_d = ST_ACCUM;
      default: state_d = ST_FIRST;
    endcase
  end

  always_comb begin
    price_ready = (state_q == ST_FIRST) || (state_q == ST_ACCUM);
    div_start   = !div_busy && ((state_q == ST_DIV_G) ||
                                (state_q == ST_DIV_L) ||
                                (state_q == ST_DIV_R));
  end

  // warm doubles as the seed/run mode flag: it only rises
  // as the seeding DIV_R retires
  always_comb begin
    num_raw = '0;
    div_den = 32'(N);
    unique case (1'b1)
      state_q == ST_DIV_G:
        num_raw = warm_q ? run_num(avg_g_q, gain_q) : div_t'(sum_g_q);
      state_q == ST_DIV_L:
        num_raw = warm_q ? run_num(avg_l_q, loss_q) : div_t'(sum_l_q);
      state_q == ST_DIV_R: begin
        num_raw = div_t'(avg_g_q) * div_t'(RSI_SCALE);
        div_den = avg_sum;
      end
      default: ;
    endcase
`ifdef RSI_ROUND_EN
    div_num = num_raw + div_t'(div_den >> 1);
`else
    div_num = num_raw;
`endif
  end

  seq_divider u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (clr),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // a zero denominator still runs the divider so the
  // latency matches; its quotient is simply ignored
  always_comb begin
    if (avg_sum == '0)
      rsi_new = RSI_50;
    else if (div_quo > div_t'(RSI_100))
      rsi_new = RSI_100;
    else
      rsi_new = div_quo[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      sum_g_q     <= '0;
      sum_l_q     <= '0;
      avg_g_q     <= '0;
      avg_l_q     <= '0;
      gain_q      <= '0;
      loss_q      <= '0;
      warm_q      <= 1'b0;
      rsi_q       <= '0;
      rsi_valid_q <= 1'b0;
    end else if (clr) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      sum_g_q     <= '0;
      sum_l_q     <= '0;
      avg_g_q     <= '0;
      avg_l_q     <= '0;
      gain_q      <= '0;
      loss_q      <= '0;
      warm_q      <= 1'b0;
      rsi_q       <= '0;
      rsi_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        prev_q <= price;
        if (state_q == ST_ACCUM) begin
          gain_q <= g32;
          loss_q <= l32;
          if (!warm_q) begin
            sum_g_q <= sum_g_q + g32;
            sum_l_q <= sum_l_q + l32;
            cnt_q   <= cnt_q + 8'd1;
          end
        end
      end
      if (div_done) begin
        unique case (state_q)
          ST_DIV_G: avg_g_q <= div_quo[31:0];
          ST_DIV_L: avg_l_q <= div_quo[31:0];
          ST_DIV_R: begin
            rsi_q  <= rsi_new;
            warm_q <= 1'b1;
          end
          default: ;
        endcase
      end
      // result is offered one cycle after it lands in rsi_q
      rsi_valid_q <= (state_q == ST_OUT) &&
                     !(rsi_valid_q && rsi_ready);
    end
  end

  assign rsi_valid = rsi_valid_q;
  assign rsi       = rsi_q;
  assign warm      = warm_q;

endmodule

// File: tb/tb_rsi_engine_ctrl.sv
// Directed bench for rsi_engine_ctrl (default N=14, DIV_W=48).
// Scenario tasks check inline; one summary line at the end.
module tb_rsi_engine_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        price_valid;
  logic        price_ready;
  logic [15:0] price;
  logic        rsi_valid;
  logic        rsi_ready;
  logic [15:0] rsi;
  logic        warm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rsi_engine_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .price_valid (price_valid),
    .price_ready (price_ready),
    .price       (price),
    .rsi_valid   (rsi_valid),
    .rsi_ready   (rsi_ready),
    .rsi         (rsi),
    .warm        (warm)
  );

  task automatic push(input logic [15:0] p);
    int n = 0;
    @(negedge clk);
    price       = p;
    price_valid = 1'b1;
    while (!price_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!price_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout price=%h ready=%b want 1", p, price_ready);
    end
    @(posedge clk);
    #1 price_valid = 1'b0;
  endtask

  task automatic wait_rsi(input string nm, input logic [15:0] exp);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rsi_valid && n < 400);
    total++;
    if (n !== 148) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=148", nm, n);
    end
    total++;
    if (rsi !== exp) begin
      bad++;
      $display("FAIL %s_rsi got=%h want=%h", nm, rsi, exp);
    end
  endtask

  task automatic handshake(input string nm);
    @(negedge clk);
    rsi_ready = 1'b1;
    @(posedge clk);
    #1 rsi_ready = 1'b0;
    total++;
    if (rsi_valid !== 1'b0 || price_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_hs valid=%b ready=%b want 0/1",
               nm, rsi_valid, price_ready);
    end
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic push_ramp(input int cnt);
    for (int i = 0; i < cnt; i++)
      push(16'h0A00 + 16'(i * 256));
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    clr         = 1'b0;
    price_valid = 1'b1;
    price       = 16'h1234;
    rsi_ready   = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (price_ready !== 1'b1 || rsi_valid !== 1'b0 ||
        rsi !== 16'h0 || warm !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b%b/%h/%b want 1 0 0000 0",
               price_ready, rsi_valid, rsi, warm);
    end
    price_valid = 1'b0;
    rst_n       = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (price_ready !== 1'b1 || rsi_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got=%b%b want 10", price_ready, rsi_valid);
    end
  endtask

  task automatic test_ramp();
    push_ramp(14);
    total++;
    if (price_ready !== 1'b1 || rsi_valid !== 1'b0 || warm !== 1'b0) begin
      bad++;
      $display("FAIL ramp_pre15 got=%b%b%b want 100",
               price_ready, rsi_valid, warm);
    end
    push(16'h1800);
    wait_rsi("ramp", 16'h6400);
    total++;
    if (warm !== 1'b1) begin
      bad++;
      $display("FAIL ramp_warm got=%b want 1", warm);
    end
    handshake("ramp");
  endtask

  task automatic test_run_update();
    push(16'h1600);
    wait_rsi("run", 16'h56AA);
    total++;
    if (dut.avg_g_q !== 32'h0000EDB6 || dut.avg_l_q !== 32'h00002492) begin
      bad++;
      $display("FAIL run_avgs got=%h/%h want 0000edb6/00002492",
               dut.avg_g_q, dut.avg_l_q);
    end
    handshake("run");
  endtask

  task automatic test_flat();
    do_clr();
    repeat (15) push(16'h3200);
    wait_rsi("flat", 16'h3200);
    handshake("flat");
  endtask

  task automatic test_back_pressure();
    do_clr();
    for (int i = 0; i < 15; i++)
      push((i % 2 == 0) ? 16'h0A00 : 16'h0B00);
    wait_rsi("alt", 16'h3200);
    price       = 16'h0B00;
    price_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (rsi !== 16'h3200 || rsi_valid !== 1'b1 || price_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold rsi=%h v=%b pr=%b want 3200 1 0",
                 rsi, rsi_valid, price_ready);
      end
    end
    rsi_ready = 1'b1;
    @(posedge clk);
    #1 rsi_ready = 1'b0;
    total++;
    if (rsi_valid !== 1'b0 || price_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release v=%b pr=%b want 0 1", rsi_valid, price_ready);
    end
    @(posedge clk);
    #1 price_valid = 1'b0;
    total++;
    if (price_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept price_ready=%b want 0", price_ready);
    end
    wait_rsi("bp_next", 16'h3592);
    handshake("bp_next");
  endtask

  task automatic test_abort(input bit use_rst, input string nm);
    bit seen;
    do_clr();
    push_ramp(15);
    repeat (60) @(posedge clk);
    #1;
    if (use_rst) rst_n = 1'b0;
    else         clr   = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr   = 1'b0;
    total++;
    if (warm !== 1'b0 || rsi_valid !== 1'b0 ||
        price_ready !== 1'b1 || rsi !== 16'h0) begin
      bad++;
      $display("FAIL %s_state w=%b v=%b pr=%b rsi=%h want 0 0 1 0000",
               nm, warm, rsi_valid, price_ready, rsi);
    end
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (rsi_valid) seen = 1'b1;
    end
    push_ramp(14);
    repeat (200) begin
      @(negedge clk);
      if (rsi_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL %s_no_output rsi_valid_seen=%b want 0", nm, seen);
    end
    push(16'h1800);
    wait_rsi(nm, 16'h6400);
    handshake(nm);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_run_update();
    test_flat();
    test_back_pressure();
    test_abort(1'b0, "abort_clr");
    test_abort(1'b1, "abort_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
